// File: rtl/parity_burst_pkg.sv
// Shared types, constants and a reference parity helper for the parity burst controller.
package parity_burst_pkg;

    typedef enum logic {
        PASS    = 1'b0,
        TRAILER = 1'b1
    } state_t;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    localparam int PARITY_CALC_W = 64;

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_calc(input logic [PARITY_CALC_W-1:0] data,
                                         input logic                     ptype);
        return (^data) ^ ptype;
    endfunction

endpackage

// File: rtl/parity_generator.sv
// Single-bit parity of a word: XOR reduction, inverted for odd parity.
module parity_generator #(
    parameter int DATA_WIDTH  = 32,
    parameter int PARITY_TYPE = 0
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_parity
);

    assign o_parity = (^i_data) ^ (PARITY_TYPE != 0);

endmodule

// File: rtl/parity_burst_ctrl.sv
// Tags each word with parity and appends a column-parity trailer per burst (or on flush).
// Optional parity corruption for link testing: define PARITY_BURST_ERR_INJECT_EN.
module parity_burst_ctrl
    import parity_burst_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_LEN   = 16,
    parameter int PARITY_TYPE = 0,
    parameter int CNT_WIDTH   = $clog2(BURST_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  flush,
`ifdef PARITY_BURST_ERR_INJECT_EN
    input  logic                  err_inject,
`endif
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_parity,
    output logic                  m_trailer,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  burst_cnt
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BURST_LEN - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_parity;
    logic                  r_m_trailer;
    logic                  r_m_valid;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_slot_free;
    logic                  w_s_ready;
    logic                  w_hs;
    logic                  w_load_data;
    logic                  w_load_trl;
    logic                  w_par_s;
    logic                  w_par_acc;
    logic                  w_inj;

    assign w_slot_free = !r_m_valid || m_ready;
    assign w_hs        = s_valid && w_s_ready;

    parity_generator #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PARITY_TYPE (PARITY_TYPE)
    ) u_par_data (
        .i_data   (s_data),
        .o_parity (w_par_s)
    );

    parity_generator #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PARITY_TYPE (PARITY_TYPE)
    ) u_par_acc (
        .i_data   (r_acc),
        .o_parity (w_par_acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= PASS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A flush only closes a burst that has, or is about to have, at least one word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PASS: begin
                if ((w_hs && (r_cnt == LAST_CNT)) || (flush && ((r_cnt != '0) || w_hs))) begin
                    w_state_nxt = TRAILER;
                end
            end
            TRAILER: begin
                if (w_slot_free) begin
                    w_state_nxt = PASS;
                end
            end
            default: w_state_nxt = PASS;
        endcase
    end

    always_comb begin
        w_s_ready   = 1'b0;
        w_load_data = 1'b0;
        w_load_trl  = 1'b0;
        case (r_state)
            PASS: begin
                w_s_ready   = w_slot_free;
                w_load_data = s_valid && w_slot_free;
            end
            TRAILER: begin
                w_load_trl = w_slot_free;
            end
            default: ;
        endcase
    end

`ifdef PARITY_BURST_ERR_INJECT_EN
    logic r_err_pend;

    // A new request wins over the clear so a pulse coinciding with a load is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_pend <= 1'b0;
        end else if (err_inject) begin
            r_err_pend <= 1'b1;
        end else if (w_load_data) begin
            r_err_pend <= 1'b0;
        end
    end

    assign w_inj = r_err_pend;
`else
    assign w_inj = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_data    <= '0;
            r_m_parity  <= 1'b0;
            r_m_trailer <= 1'b0;
            r_m_valid   <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else if (w_load_data) begin
            r_m_data    <= s_data;
            r_m_parity  <= w_par_s ^ w_inj;
            r_m_trailer <= 1'b0;
            r_m_valid   <= 1'b1;
            r_acc       <= r_acc ^ s_data;
            r_cnt       <= r_cnt + CNT_WIDTH'(1);
        end else if (w_load_trl) begin
            r_m_data    <= r_acc;
            r_m_parity  <= w_par_acc;
            r_m_trailer <= 1'b1;
            r_m_valid   <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else if (m_ready) begin
            r_m_valid   <= 1'b0;
        end
    end

    assign s_ready   = w_s_ready;
    assign m_data    = r_m_data;
    assign m_parity  = r_m_parity;
    assign m_trailer = r_m_trailer;
    assign m_valid   = r_m_valid;
    assign burst_cnt = r_cnt;

endmodule

// File: doc/parity_burst_ctrl.md
Name: parity_burst_ctrl

Overview:
- Stream controller that sequences parity generation over bursts of data words.
- Tags every accepted word with a single parity bit.
- Keeps a running column parity (bitwise XOR) across the burst and emits that as a trailer word after BURST_LEN words, or earlier on a flush request.
- Sits between a word producer and a serial/link framer, using valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 32, word width in bits (>=1).
- BURST_LEN, 16, data words per burst before the trailer (>=1).
- PARITY_TYPE, 0, 0 = even parity, 1 = odd parity; applies to data and trailer words.
- CNT_WIDTH, $clog2(BURST_LEN+1), width of the burst counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- s_data  in  DATA_WIDTH  input word.
- s_valid  in  1  input word valid.
- s_ready  out  1  controller can accept the input word.
- flush  in  1  close the current burst early (level, sampled each cycle).
- m_data  out  DATA_WIDTH  output word (data or trailer).
- m_parity  out  1  parity bit of m_data.
- m_trailer  out  1  m_data is a trailer word.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream accepts output.
- burst_cnt  out  CNT_WIDTH  data words accepted in the current burst.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset values:
  - m_valid=0, m_data=0, m_parity=0, m_trailer=0, burst_cnt=0.
  - Accumulator=0, state=PASS.
- Reset asserted mid-burst discards the partial burst, the accumulator and any pending output word; no trailer is emitted for it.
- Parity function: p(x) = ^x, inverted when PARITY_TYPE=1.
- Output slot free: slot_free = !m_valid || m_ready.
- States:
  - PASS: s_ready = slot_free. On an input handshake (s_valid && s_ready):
    - load m_data=s_data, m_parity=p(s_data), m_trailer=0, m_valid=1;
    - acc ^= s_data; burst_cnt++.
    - Latency from input to output is 1 cycle.
  - PASS -> TRAILER when either:
    - a handshake occurs with burst_cnt==BURST_LEN-1; or
    - flush=1 and (burst_cnt>0 or a handshake occurs in the same cycle).
  - Flush with a simultaneous handshake includes that word in the burst before the trailer.
  - Flush with burst_cnt==0 and no handshake is ignored; empty bursts never produce trailers.
  - TRAILER: s_ready=0. When slot_free:
    - load m_data=acc, m_parity=p(acc), m_trailer=1, m_valid=1;
    - clear acc and burst_cnt; return to PASS.
    - The trailer immediately follows the last data word (minimum one bubble-free back-to-back output).
- Output register: m_valid clears on m_ready when no new word loads. Output fields are stable while m_valid && !m_ready.
- Counter: burst_cnt never exceeds BURST_LEN-1 in PASS; with BURST_LEN=1 every word is followed by a trailer.
- flush in TRAILER has no effect.

Optional Feature:
- Macro: PARITY_BURST_ERR_INJECT_EN.
- When defined:
  - Adds input err_inject (1 bit, pulse).
  - A pending flag is set on err_inject.
  - The next data word loaded into the output has m_parity inverted, then the flag clears.
  - Trailers are never corrupted, and the accumulator uses the true data.
  - Reset clears the pending flag.
- When undefined: the port does not exist and parity is always correct.

Decomposition:
- Shared package parity_burst_pkg holds:
  - state typedef (PASS, TRAILER);
  - parity-type constants EVEN=0, ODD=1;
  - function parity_calc(data, type) for bench reuse.
- One sub-module, the library's parity_generator, instantiated twice: once on s_data and once on the accumulator, with PARITY_TYPE passed through.

Test Plan:
- DATA_WIDTH=8, BURST_LEN=4, even parity, m_ready=1. Send 0x01,0x03,0x07,0x0F -> data words with parity 1,0,1,0, then trailer 0x0A with parity 0 and m_trailer=1.
- Same stimulus with m_ready low for 3 cycles after the 2nd word -> outputs held stable; s_ready=0; no loss or duplication; identical sequence.
- Send 0xFF,0x80, then flush -> trailer 0x7F with parity 1. A flush at burst_cnt=0 produces nothing.
- PARITY_TYPE=1: word 0x00 -> m_parity=1; trailer of 0x00 x4 -> 0x00 with parity 1.
- Reset asserted after 3 words -> no trailer; next burst of 4 words produces a trailer over only those 4 words; all outputs 0 during reset.
- PARITY_BURST_ERR_INJECT_EN: pulse err_inject, send 0x01 -> m_parity=0. Next word 0x01 -> parity 1. Trailer still correct.
